// File: rtl/fetch_queue_stage.sv
// Fetch stage: one I-cache lookup per cycle, kill lanes past the first taken branch, and push
// resolved groups into a small fetch queue. Define RSD_FETCH_QUEUE_PERF_EN for perf outputs.
module fetch_queue_stage #(
    parameter int unsigned FETCH_WIDTH     = 4,
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter int unsigned PC_WIDTH        = 32,
    parameter int unsigned INSN_WIDTH      = 32,
    parameter int unsigned PRED_META_WIDTH = 64
) (
    input  logic                                   clk,
    input  logic                                   rstN,
    input  logic                                   flush,
    input  logic [FETCH_WIDTH-1:0]                 inValid,
    input  logic [FETCH_WIDTH*PC_WIDTH-1:0]        inPC,
    output logic                                   inReady,
    output logic                                   icRE,
    output logic [PC_WIDTH-1:0]                    icReadAddr,
    input  logic                                   icReadHit,
    input  logic [FETCH_WIDTH*INSN_WIDTH-1:0]      icReadData,
    input  logic [FETCH_WIDTH-1:0]                 predTaken,
    input  logic [FETCH_WIDTH*PC_WIDTH-1:0]        predAddr,
    input  logic [FETCH_WIDTH*PRED_META_WIDTH-1:0] predMeta,
    output logic [FETCH_WIDTH-1:0]                 updateBrHistory,
    output logic                                   missStart,
    output logic [FETCH_WIDTH-1:0]                 outValid,
    output logic [FETCH_WIDTH*PC_WIDTH-1:0]        outPC,
    output logic [FETCH_WIDTH*INSN_WIDTH-1:0]      outInsn,
    output logic [FETCH_WIDTH*PC_WIDTH-1:0]        outPredAddr,
    output logic [FETCH_WIDTH*PRED_META_WIDTH-1:0] outPredMeta,
    output logic [FETCH_WIDTH-1:0]                 outPredTaken,
    input  logic                                   outReady
`ifdef RSD_FETCH_QUEUE_PERF_EN
    ,
    output logic                                   perfIcMiss,
    output logic                                   perfQueueFullStall,
    output logic [31:0]                            perfStallCycles
`endif
);

    localparam int unsigned PtrW   = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned IdxW   = PtrW - 1;
    localparam int unsigned Stride = INSN_WIDTH / 8;

    typedef enum logic [1:0] {StEmpty, StLookup, StStall} fetchStateT;

    fetchStateT stateQ, stateD;

    logic [FETCH_WIDTH-1:0]                 fetchValidQ;
    logic [FETCH_WIDTH*PC_WIDTH-1:0]        fetchPcQ;
    logic [FETCH_WIDTH-1:0]                 holdTakenQ;
    logic [FETCH_WIDTH*PC_WIDTH-1:0]        holdAddrQ;
    logic [FETCH_WIDTH*PRED_META_WIDTH-1:0] holdMetaQ;
    logic [PtrW-1:0]                        headQ, tailQ;

    logic [FETCH_WIDTH-1:0]                 qValid    [QUEUE_DEPTH];
    logic [FETCH_WIDTH-1:0]                 qTaken    [QUEUE_DEPTH];
    logic [FETCH_WIDTH*PC_WIDTH-1:0]        qPc       [QUEUE_DEPTH];
    logic [FETCH_WIDTH*INSN_WIDTH-1:0]      qInsn     [QUEUE_DEPTH];
    logic [FETCH_WIDTH*PC_WIDTH-1:0]        qPredAddr [QUEUE_DEPTH];
    logic [FETCH_WIDTH*PRED_META_WIDTH-1:0] qPredMeta [QUEUE_DEPTH];

    logic [PtrW-1:0] count;
    logic [IdxW-1:0] headIdx, tailIdx;
    logic            notEmpty, full, pop, push, load;

    logic [FETCH_WIDTH-1:0]                 selTaken;
    logic [FETCH_WIDTH*PC_WIDTH-1:0]        selAddr;
    logic [FETCH_WIDTH*PRED_META_WIDTH-1:0] selMeta;
    logic [FETCH_WIDTH-1:0]                 laneValid;
    logic [FETCH_WIDTH-1:0]                 pushTaken;
    logic [FETCH_WIDTH*PC_WIDTH-1:0]        pushPredAddr;
    logic                                   seenTaken;

    assign count    = tailQ - headQ;
    assign headIdx  = headQ[IdxW-1:0];
    assign tailIdx  = tailQ[IdxW-1:0];
    assign notEmpty = (count != '0);
    assign full     = (count == PtrW'(QUEUE_DEPTH));
    assign pop      = notEmpty && outReady;
    assign push     = (stateQ != StEmpty) && icReadHit && (!full || pop) && !flush;
    assign inReady  = ((stateQ == StEmpty) || push) && !flush;
    assign load     = inReady && (|inValid);

    // The predictor has moved on once we stall, so STALL must use the copy taken in LOOKUP.
    assign selTaken = (stateQ == StLookup) ? predTaken : holdTakenQ;
    assign selAddr  = (stateQ == StLookup) ? predAddr  : holdAddrQ;
    assign selMeta  = (stateQ == StLookup) ? predMeta  : holdMetaQ;

    always_comb begin
        seenTaken    = 1'b0;
        laneValid    = '0;
        pushPredAddr = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            laneValid[i] = fetchValidQ[i] && !seenTaken;
            seenTaken    = seenTaken || (fetchValidQ[i] && selTaken[i]);
            pushPredAddr[i*PC_WIDTH +: PC_WIDTH] = selTaken[i]
                ? selAddr[i*PC_WIDTH +: PC_WIDTH]
                : fetchPcQ[i*PC_WIDTH +: PC_WIDTH] + PC_WIDTH'(Stride);
        end
    end

    assign pushTaken = selTaken & laneValid;

    always_comb begin
        stateD = stateQ;
        if (flush) begin
            stateD = StEmpty;
        end else begin
            unique case (stateQ)
                StEmpty:  if (load) stateD = StLookup;
                StLookup,
                StStall: begin
                    if (push) stateD = load ? StLookup : StEmpty;
                    else      stateD = StStall;
                end
                default:  stateD = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stateQ      <= StEmpty;
            fetchValidQ <= '0;
            fetchPcQ    <= '0;
            holdTakenQ  <= '0;
            holdAddrQ   <= '0;
            holdMetaQ   <= '0;
            headQ       <= '0;
            tailQ       <= '0;
        end else begin
            stateQ <= stateD;
            if (flush) begin
                fetchValidQ <= '0;
            end else if (load) begin
                fetchValidQ <= inValid;
                fetchPcQ    <= inPC;
            end
            if ((stateQ == StLookup) && !push && !flush) begin
                holdTakenQ <= predTaken;
                holdAddrQ  <= predAddr;
                holdMetaQ  <= predMeta;
            end
            if (flush) begin
                headQ <= '0;
                tailQ <= '0;
            end else begin
                if (push) tailQ <= tailQ + 1'b1;
                if (pop)  headQ <= headQ + 1'b1;
            end
        end
    end

    // Storage needs no reset: every read is gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            qValid[tailIdx]    <= laneValid;
            qTaken[tailIdx]    <= pushTaken;
            qPc[tailIdx]       <= fetchPcQ;
            qInsn[tailIdx]     <= icReadData;
            qPredAddr[tailIdx] <= pushPredAddr;
            qPredMeta[tailIdx] <= selMeta;
        end
    end

    assign outValid     = notEmpty ? qValid[headIdx]    : '0;
    assign outPredTaken = notEmpty ? qTaken[headIdx]    : '0;
    assign outPC        = notEmpty ? qPc[headIdx]       : '0;
    assign outInsn      = notEmpty ? qInsn[headIdx]     : '0;
    assign outPredAddr  = notEmpty ? qPredAddr[headIdx] : '0;
    assign outPredMeta  = notEmpty ? qPredMeta[headIdx] : '0;

    assign icRE            = (stateQ != StEmpty);
    assign icReadAddr      = icRE ? fetchPcQ[PC_WIDTH-1:0] : '0;
    assign updateBrHistory = (stateQ == StLookup) ? fetchValidQ : '0;
    assign missStart       = (stateQ == StLookup) && !icReadHit;

`ifdef RSD_FETCH_QUEUE_PERF_EN
    logic [31:0] stallCyclesQ;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stallCyclesQ <= '0;
        end else if (stateQ == StStall) begin
            stallCyclesQ <= stallCyclesQ + 32'd1;
        end
    end

    assign perfIcMiss         = missStart;
    assign perfQueueFullStall = (stateQ != StEmpty) && icReadHit && full && !pop;
    assign perfStallCycles    = stallCyclesQ;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed self-checking bench for fetch_queue_stage (default parameters, perf build off).
module tb_fetch_queue_stage;

    logic         clk;
    logic         rstN;
    logic         flush;
    logic [3:0]   inValid;
    logic [127:0] inPC;
    logic         inReady;
    logic         icRE;
    logic [31:0]  icReadAddr;
    logic         icReadHit;
    logic [127:0] icReadData;
    logic [3:0]   predTaken;
    logic [127:0] predAddr;
    logic [255:0] predMeta;
    logic [3:0]   updateBrHistory;
    logic         missStart;
    logic [3:0]   outValid;
    logic [127:0] outPC;
    logic [127:0] outInsn;
    logic [127:0] outPredAddr;
    logic [255:0] outPredMeta;
    logic [3:0]   outPredTaken;
    logic         outReady;

    int testCount = 0;
    int failCount = 0;

    fetch_queue_stage dut (
        .clk             (clk),
        .rstN            (rstN),
        .flush           (flush),
        .inValid         (inValid),
        .inPC            (inPC),
        .inReady         (inReady),
        .icRE            (icRE),
        .icReadAddr      (icReadAddr),
        .icReadHit       (icReadHit),
        .icReadData      (icReadData),
        .predTaken       (predTaken),
        .predAddr        (predAddr),
        .predMeta        (predMeta),
        .updateBrHistory (updateBrHistory),
        .missStart       (missStart),
        .outValid        (outValid),
        .outPC           (outPC),
        .outInsn         (outInsn),
        .outPredAddr     (outPredAddr),
        .outPredMeta     (outPredMeta),
        .outPredTaken    (outPredTaken),
        .outReady        (outReady)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setGroup(input logic [31:0] base, input logic [3:0] valid);
        inValid = valid;
        for (int i = 0; i < 4; i++) inPC[i*32 +: 32] = base + 32'(4 * i);
    endtask

    function automatic logic [31:0] lane32(input logic [127:0] bus, input int i);
        return bus[i*32 +: 32];
    endfunction

    function automatic logic [63:0] lane64(input logic [255:0] bus, input int i);
        return bus[i*64 +: 64];
    endfunction

    initial begin
        rstN       = 1'b0;
        flush      = 1'b0;
        inValid    = '0;
        inPC       = '0;
        icReadHit  = 1'b1;
        predTaken  = '0;
        predAddr   = '0;
        predMeta   = '0;
        outReady   = 1'b1;
        for (int i = 0; i < 4; i++) icReadData[i*32 +: 32] = 32'hA000_0000 + 32'(i);

        // Reset state
        #2;
        checkEq("rst.outValid", outValid, 0);
        checkEq("rst.inReady", inReady, 1);
        checkEq("rst.icRE", icRE, 0);
        checkEq("rst.missStart", missStart, 0);
        checkEq("rst.ubh", updateBrHistory, 0);
        checkEq("rst.outPC", outPC[63:0], 0);
        tick();
        rstN = 1'b1;

        // Streaming hits
        setGroup(32'h1000, 4'hF);
        @(negedge clk);
        checkEq("stream.inReady", inReady, 1);
        tick();
        setGroup(32'h1010, 4'hF);
        @(negedge clk);
        checkEq("stream.icRE", icRE, 1);
        checkEq("stream.icAddr", icReadAddr, 32'h1000);
        checkEq("stream.ubh", updateBrHistory, 4'hF);
        checkEq("stream.latency", outValid, 0);
        tick();
        setGroup(32'h1020, 4'hF);
        @(negedge clk);
        checkEq("stream.v0", outValid, 4'hF);
        checkEq("stream.pc0", lane32(outPC, 0), 32'h1000);
        checkEq("stream.pc3", lane32(outPC, 3), 32'h100C);
        checkEq("stream.pa0", lane32(outPredAddr, 0), 32'h1004);
        checkEq("stream.pa3", lane32(outPredAddr, 3), 32'h1010);
        checkEq("stream.insn2", lane32(outInsn, 2), 32'hA000_0002);
        tick();
        setGroup(32'h0, 4'h0);
        @(negedge clk);
        checkEq("stream.pc1", lane32(outPC, 0), 32'h1010);
        tick();
        @(negedge clk);
        checkEq("stream.pc2", lane32(outPC, 0), 32'h1020);
        checkEq("stream.v2", outValid, 4'hF);
        tick();
        @(negedge clk);
        checkEq("stream.drain", outValid, 0);
        checkEq("stream.idle", icRE, 0);
        tick();

        // Taken branch in lane 1
        setGroup(32'h1000, 4'hF);
        tick();
        setGroup(32'h0, 4'h0);
        predTaken = 4'b0010;
        predAddr[32 +: 32] = 32'h2000;
        predMeta[64 +: 64] = 64'h1111_2222_3333_4444;
        @(negedge clk);
        checkEq("taken.ubh", updateBrHistory, 4'hF);
        checkEq("taken.miss", missStart, 0);
        tick();
        predTaken = '0;
        predAddr  = '0;
        predMeta  = '0;
        @(negedge clk);
        checkEq("taken.valid", outValid, 4'b0011);
        checkEq("taken.taken", outPredTaken, 4'b0010);
        checkEq("taken.pa1", lane32(outPredAddr, 1), 32'h2000);
        checkEq("taken.pa0", lane32(outPredAddr, 0), 32'h1004);
        checkEq("taken.meta1", lane64(outPredMeta, 1), 64'h1111_2222_3333_4444);
        checkEq("taken.ubhAfter", updateBrHistory, 0);
        tick();
        @(negedge clk);
        checkEq("taken.drain", outValid, 0);
        tick();

        // Five-cycle miss with predictor inputs changing during the stall
        setGroup(32'h3000, 4'hF);
        tick();
        setGroup(32'h3100, 4'hF);
        icReadHit = 1'b0;
        predTaken = 4'b0100;
        predAddr[64 +: 32] = 32'h4000;
        predMeta[128 +: 64] = 64'hAAAA;
        @(negedge clk);
        checkEq("miss.start", missStart, 1);
        checkEq("miss.inReady0", inReady, 0);
        checkEq("miss.ubhLookup", updateBrHistory, 4'hF);
        tick();
        for (int k = 0; k < 4; k++) begin
            predTaken = 4'b0001;
            predAddr  = {4{32'h5000 + 32'(k)}};
            predMeta  = {4{64'(k)}};
            @(negedge clk);
            checkEq("miss.pulse", missStart, 0);
            checkEq("miss.inReady", inReady, 0);
            checkEq("miss.ubhStall", updateBrHistory, 0);
            checkEq("miss.outValid", outValid, 0);
            tick();
        end
        icReadHit = 1'b1;
        setGroup(32'h0, 4'h0);
        @(negedge clk);
        checkEq("miss.hitReady", inReady, 1);
        tick();
        predTaken = '0;
        predAddr  = '0;
        predMeta  = '0;
        @(negedge clk);
        checkEq("miss.valid", outValid, 4'b0111);
        checkEq("miss.taken", outPredTaken, 4'b0100);
        checkEq("miss.pa2", lane32(outPredAddr, 2), 32'h4000);
        checkEq("miss.pa0", lane32(outPredAddr, 0), 32'h3004);
        checkEq("miss.meta2", lane64(outPredMeta, 2), 64'hAAAA);
        tick();

        // Fill the queue, stall, then pop and push together across pointer wrap
        outReady = 1'b0;
        for (int g = 0; g < 5; g++) begin
            setGroup(32'h6000 + 32'(16 * g), 4'hF);
            tick();
        end
        setGroup(32'h6050, 4'hF);
        @(negedge clk);
        checkEq("full.inReady", inReady, 0);
        checkEq("full.ubhLookup", updateBrHistory, 4'hF);
        checkEq("full.head", lane32(outPC, 0), 32'h6000);
        tick();
        @(negedge clk);
        checkEq("full.stallReady", inReady, 0);
        checkEq("full.stallRE", icRE, 1);
        checkEq("full.stallUbh", updateBrHistory, 0);
        checkEq("full.noMiss", missStart, 0);
        tick();
        outReady = 1'b1;
        setGroup(32'h0, 4'h0);
        @(negedge clk);
        checkEq("full.popPushReady", inReady, 1);
        checkEq("full.order0", lane32(outPC, 0), 32'h6000);
        tick();
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            checkEq("full.order", lane32(outPC, 0), 32'h6000 + 32'(16 * k));
            checkEq("full.valid", outValid, 4'hF);
            tick();
        end
        @(negedge clk);
        checkEq("full.drain", outValid, 0);
        tick();

        // Flush with three queued groups and a miss pending
        outReady = 1'b0;
        for (int g = 0; g < 4; g++) begin
            setGroup(32'h7000 + 32'(16 * g), 4'hF);
            tick();
        end
        icReadHit = 1'b0;
        setGroup(32'h0, 4'h0);
        @(negedge clk);
        checkEq("flush.missStart", missStart, 1);
        tick();
        flush = 1'b1;
        setGroup(32'h7040, 4'hF);
        @(negedge clk);
        checkEq("flush.head", lane32(outPC, 0), 32'h7000);
        checkEq("flush.inReady", inReady, 0);
        tick();
        flush = 1'b0;
        icReadHit = 1'b1;
        setGroup(32'h0, 4'h0);
        @(negedge clk);
        checkEq("flush.outValid", outValid, 0);
        checkEq("flush.icRE", icRE, 0);
        checkEq("flush.inReady1", inReady, 1);
        tick();
        @(negedge clk);
        checkEq("flush.dropped", outValid, 0);
        tick();

        // Asynchronous reset mid-stream
        outReady = 1'b1;
        setGroup(32'h8000, 4'hF);
        tick();
        setGroup(32'h8010, 4'hF);
        tick();
        setGroup(32'h0, 4'h0);
        @(negedge clk);
        checkEq("arst.before", lane32(outPC, 0), 32'h8000);
        rstN = 1'b0;
        #1;
        checkEq("arst.outValid", outValid, 0);
        checkEq("arst.inReady", inReady, 1);
        checkEq("arst.icRE", icRE, 0);
        checkEq("arst.outPC", lane32(outPC, 0), 0);
        tick();
        rstN = 1'b1;
        setGroup(32'h9000, 4'hF);
        tick();
        setGroup(32'h0, 4'h0);
        @(negedge clk);
        checkEq("arst.lat1", outValid, 0);
        checkEq("arst.icAddr", icReadAddr, 32'h9000);
        tick();
        @(negedge clk);
        checkEq("arst.valid", outValid, 4'hF);
        checkEq("arst.pc", lane32(outPC, 0), 32'h9000);
        tick();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
